// File: rtl/calc_pkg.sv
// Shared definitions for the calculator command scheduler: core status
// encodings, keypad command codes and the scheduler state type.
package calc_pkg;

    // Status values reported by the calc core
    localparam logic [1:0] ST_ERR     = 2'b00;
    localparam logic [1:0] ST_BUSY    = 2'b01;
    localparam logic [1:0] ST_READY   = 2'b10;
    localparam logic [1:0] ST_ILLEGAL = 2'b11;

    // Command codes presented to the core (digits 0-9 are passed as-is)
    localparam logic [3:0] CMD_ADD = 4'b1010;
    localparam logic [3:0] CMD_SUB = 4'b1011;
    localparam logic [3:0] CMD_MUL = 4'b1100;
    localparam logic [3:0] CMD_EQ  = 4'b1110;
    localparam logic [3:0] CMD_BS  = 4'b1111;
    localparam logic [3:0] CMD_BAD = 4'b1101;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_BUSY,
        S_ERROR
    } sched_state_t;

    // The core is faulted when it reports an error or an illegal status
    function automatic logic statusFault(input logic [1:0] status);
        return (status == ST_ERR) || (status == ST_ILLEGAL);
    endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Small circular FIFO holding pending key codes. Purely a data buffer:
// it knows nothing about what the codes mean. Flush wins over push/pop.
module cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    flush_i,
    input  logic                    push_i,
    input  logic [WIDTH-1:0]        data_i,
    input  logic                    pop_i,
    output logic [WIDTH-1:0]        data_o,
    output logic [$clog2(DEPTH):0]  count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = 1;
    localparam logic [AW:0]   CNT_ONE = 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wrPtr_q;
    logic [AW-1:0]    rdPtr_q;
    logic [AW:0]      count_q;

    assign data_o  = mem_q[rdPtr_q];
    assign count_o = count_q;

    // Storage array; written on every accepted push, never reset
    always_ff @(posedge clock) begin
        if (push_i && !flush_i) begin
            mem_q[wrPtr_q] <= data_i;
        end
    end

    // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else if (flush_i) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (push_i) begin
                wrPtr_q <= wrPtr_q + PTR_ONE;
            end
            if (pop_i) begin
                rdPtr_q <= rdPtr_q + PTR_ONE;
            end
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/calc_cmd_sched.sv
// Command scheduler between the keypad and the calc core. Queues key codes,
// hands them to the core one at a time with a ready/busy/ready handshake,
// and recovers from core errors or hangs by pulsing the core reset.
module calc_cmd_sched
    import calc_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    key_valid,
    input  logic [3:0]              key_code,
    output logic                    key_ready,
    input  logic                    clr,
    input  logic [1:0]              calc_status,
    output logic [3:0]              cmd,
    output logic                    calc_rst,
    output logic                    issue_active,
    output logic                    err,
    output logic                    timeout,
    output logic                    dropped,
    output logic [$clog2(DEPTH):0]  fifo_count
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int TW = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
    localparam logic [TW-1:0] HANG_AT   = TW'(TIMEOUT - 2);
    localparam logic [TW-1:0] TIMER_ONE = 1;

    sched_state_t  state_q, state_d;
    logic [3:0]    cmd_q, cmd_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          err_q, err_d;
    logic          timeout_q, timeout_d;
    logic          dropped_q, dropped_d;
    logic          calcRst_q, calcRst_d;
    logic          issueActive_q, issueActive_d;

    logic          push, pop, flush;
    logic          fault, hang;
    logic [3:0]    fifoHead;
    logic [CW-1:0] fifoCount;

    cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (4)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .flush_i (flush),
        .push_i  (push),
        .data_i  (key_code),
        .pop_i   (pop),
        .data_o  (fifoHead),
        .count_o (fifoCount)
    );

    assign key_ready = (fifoCount < DEPTH_C) && (state_q != S_ERROR);
    assign push      = key_valid && key_ready && (key_code != CMD_BAD);
    assign fault     = statusFault(calc_status);
    // Incremented value would hit TIMEOUT-1 on this edge: declare a hang
    assign hang      = ((state_q == S_ISSUE) || (state_q == S_BUSY)) && (timer_q == HANG_AT);

    assign cmd          = cmd_q;
    assign calc_rst     = calcRst_q;
    assign issue_active = issueActive_q;
    assign err          = err_q;
    assign timeout      = timeout_q;
    assign dropped      = dropped_q;
    assign fifo_count   = fifoCount;

    // Next-state logic for the handshake FSM and all of its registered outputs
    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        timer_d   = timer_q;
        err_d     = err_q;
        timeout_d = timeout_q;
        calcRst_d = 1'b0;
        dropped_d = key_valid && ((state_q == S_ERROR) || (key_code == CMD_BAD));
        pop       = 1'b0;
        flush     = 1'b0;

        if ((state_q != S_ERROR) && (fault || hang)) begin
            state_d   = S_ERROR;
            cmd_d     = 4'd0;
            err_d     = 1'b1;
            timeout_d = !fault;
            flush     = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if ((fifoCount != '0) && (calc_status == ST_READY)) begin
                        state_d = S_ISSUE;
                        pop     = 1'b1;
                        cmd_d   = fifoHead;
                        timer_d = '0;
                    end
                end
                S_ISSUE: begin
                    timer_d = timer_q + TIMER_ONE;
                    if (calc_status == ST_BUSY) begin
                        state_d = S_BUSY;
                    end
                end
                S_BUSY: begin
                    timer_d = timer_q + TIMER_ONE;
                    if (calc_status == ST_READY) begin
                        state_d = S_IDLE;
                    end
                end
                S_ERROR: begin
                    if (clr) begin
                        state_d   = S_IDLE;
                        calcRst_d = 1'b1;
                        err_d     = 1'b0;
                        timeout_d = 1'b0;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        issueActive_d = (state_d == S_ISSUE) || (state_d == S_BUSY);
    end

    // State and output registers; async reset abandons any command in flight
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            cmd_q         <= 4'd0;
            timer_q       <= '0;
            err_q         <= 1'b0;
            timeout_q     <= 1'b0;
            dropped_q     <= 1'b0;
            calcRst_q     <= 1'b0;
            issueActive_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cmd_q         <= cmd_d;
            timer_q       <= timer_d;
            err_q         <= err_d;
            timeout_q     <= timeout_d;
            dropped_q     <= dropped_d;
            calcRst_q     <= calcRst_d;
            issueActive_q <= issueActive_d;
        end
    end

endmodule

// File: tb/tb_calc_cmd_sched.sv
// Directed bench for calc_cmd_sched. Accepted keys are queued as expected
// commands; a monitor pops and compares each time a new command issues.
module tb_calc_cmd_sched;
    import calc_pkg::*;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       key_valid = 1'b0;
    logic [3:0] key_code = 4'd0;
    logic       key_ready;
    logic       clr = 1'b0;
    logic [1:0] calc_status = ST_READY;
    logic [3:0] cmd;
    logic       calc_rst;
    logic       issue_active;
    logic       err;
    logic       timeout;
    logic       dropped;
    logic [2:0] fifo_count;

    int         checks = 0;
    int         errors = 0;
    logic [3:0] expQ[$];
    logic       issuePrev = 1'b0;
    logic [3:0] order[4];

    calc_cmd_sched #(
        .DEPTH   (4),
        .TIMEOUT (16)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .key_valid    (key_valid),
        .key_code     (key_code),
        .key_ready    (key_ready),
        .clr          (clr),
        .calc_status  (calc_status),
        .cmd          (cmd),
        .calc_rst     (calc_rst),
        .issue_active (issue_active),
        .err          (err),
        .timeout      (timeout),
        .dropped      (dropped),
        .fifo_count   (fifo_count)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    // Offer one key for one edge; queue it as an expected command if it should be taken
    task automatic applyStimulus(input logic [3:0] code, input logic expReady, input logic expPush);
        checkOutput("key_ready_pre", key_ready, expReady);
        key_valid = 1'b1;
        key_code  = code;
        if (expPush) expQ.push_back(code);
        @(negedge clock);
        key_valid = 1'b0;
    endtask

    // Scoreboard: each fresh entry into ISSUE must present the oldest queued key
    always @(posedge clock) begin
        #1;
        if (issue_active === 1'b1 && issuePrev !== 1'b1) begin
            if (expQ.size() == 0) checkOutput("sb_underflow", expQ.size(), 1);
            else checkOutput("sb_cmd", cmd, expQ.pop_front());
        end
        issuePrev = issue_active;
    end

    // Global time limit so the bench can never hang
    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        order[0] = 4'd1;
        order[1] = 4'd2;
        order[2] = CMD_ADD;
        order[3] = 4'd3;

        // Reset values
        tick(); tick();
        checkOutput("rst_cmd", cmd, 0);
        checkOutput("rst_calc_rst", calc_rst, 0);
        checkOutput("rst_err", err, 0);
        checkOutput("rst_timeout", timeout, 0);
        checkOutput("rst_dropped", dropped, 0);
        checkOutput("rst_count", fifo_count, 0);
        checkOutput("rst_issue", issue_active, 0);
        checkOutput("rst_key_ready", key_ready, 1);
        reset = 1'b0;
        tick();

        // Single key with empty FIFO and ready core
        $display("[TB] single command latency");
        applyStimulus(4'd5, 1'b1, 1'b1);
        checkOutput("t1_count", fifo_count, 1);
        checkOutput("t1_cmd_pre", cmd, 0);
        tick();
        checkOutput("t1_cmd", cmd, 5);
        checkOutput("t1_issue", issue_active, 1);
        checkOutput("t1_count_pop", fifo_count, 0);
        calc_status = ST_BUSY;
        repeat (10) tick();
        checkOutput("t1_busy", issue_active, 1);
        calc_status = ST_READY;
        tick();
        checkOutput("t1_idle", issue_active, 0);
        checkOutput("t1_cmd_hold", cmd, 5);

        // Fill the FIFO while the core is busy, then drain in order
        $display("[TB] fill and drain");
        calc_status = ST_BUSY;
        applyStimulus(4'd1, 1'b1, 1'b1);
        applyStimulus(4'd2, 1'b1, 1'b1);
        applyStimulus(CMD_ADD, 1'b1, 1'b1);
        applyStimulus(4'd3, 1'b1, 1'b1);
        checkOutput("t2_full_count", fifo_count, 4);
        applyStimulus(4'd4, 1'b0, 1'b0);
        checkOutput("t2_fifth_count", fifo_count, 4);
        checkOutput("t2_no_drop", dropped, 0);
        for (int i = 0; i < 4; i++) begin
            calc_status = ST_READY;
            tick();
            checkOutput("t2_cmd", cmd, order[i]);
            calc_status = ST_BUSY;
            tick();
            calc_status = ST_READY;
            tick();
        end
        checkOutput("t2_empty", fifo_count, 0);
        checkOutput("t2_idle", issue_active, 0);

        // Undefined code is discarded
        $display("[TB] undefined code");
        calc_status = ST_BUSY;
        applyStimulus(CMD_BAD, 1'b1, 1'b0);
        checkOutput("t3_dropped", dropped, 1);
        checkOutput("t3_count", fifo_count, 0);
        checkOutput("t3_cmd", cmd, 3);
        tick();
        checkOutput("t3_drop_pulse", dropped, 0);

        // Core error while busy with two keys queued, then clear
        $display("[TB] core error and clear");
        applyStimulus(4'd7, 1'b1, 1'b1);
        applyStimulus(4'd8, 1'b1, 1'b1);
        applyStimulus(4'd9, 1'b1, 1'b1);
        calc_status = ST_READY;
        tick();
        checkOutput("t4_cmd", cmd, 7);
        calc_status = ST_BUSY;
        tick();
        checkOutput("t4_queued", fifo_count, 2);
        calc_status = ST_ERR;
        tick();
        expQ.delete();
        checkOutput("t4_err", err, 1);
        checkOutput("t4_timeout", timeout, 0);
        checkOutput("t4_flush", fifo_count, 0);
        checkOutput("t4_cmd_clear", cmd, 0);
        checkOutput("t4_issue", issue_active, 0);
        calc_status = ST_READY;
        applyStimulus(4'd4, 1'b0, 1'b0);
        checkOutput("t4_dropped", dropped, 1);
        checkOutput("t4_count_err", fifo_count, 0);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        checkOutput("t4_calc_rst", calc_rst, 1);
        checkOutput("t4_err_clr", err, 0);
        checkOutput("t4_ready_back", key_ready, 1);
        tick();
        checkOutput("t4_calc_rst_pulse", calc_rst, 0);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        checkOutput("t4_clr_idle", calc_rst, 0);

        // Hang: core never accepts the command
        $display("[TB] hang detection");
        calc_status = ST_READY;
        applyStimulus(4'd6, 1'b1, 1'b1);
        tick();
        checkOutput("t5_cmd", cmd, 6);
        repeat (14) tick();
        checkOutput("t5_not_yet", err, 0);
        checkOutput("t5_still_issue", issue_active, 1);
        tick();
        checkOutput("t5_err", err, 1);
        checkOutput("t5_timeout", timeout, 1);
        checkOutput("t5_cmd_clear", cmd, 0);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        checkOutput("t5_timeout_clr", timeout, 0);
        checkOutput("t5_calc_rst", calc_rst, 1);

        // Asynchronous reset mid-BUSY with three keys queued
        $display("[TB] reset mid-command");
        calc_status = ST_BUSY;
        applyStimulus(4'd1, 1'b1, 1'b1);
        applyStimulus(4'd2, 1'b1, 1'b1);
        applyStimulus(4'd3, 1'b1, 1'b1);
        applyStimulus(4'd4, 1'b1, 1'b1);
        calc_status = ST_READY;
        tick();
        calc_status = ST_BUSY;
        tick();
        checkOutput("t6_queued", fifo_count, 3);
        checkOutput("t6_busy", issue_active, 1);
        #2;
        reset = 1'b1;
        #1;
        expQ.delete();
        checkOutput("t6_cmd", cmd, 0);
        checkOutput("t6_count", fifo_count, 0);
        checkOutput("t6_issue", issue_active, 0);
        checkOutput("t6_err", err, 0);
        checkOutput("t6_calc_rst", calc_rst, 0);
        tick();
        checkOutput("t6_calc_rst_hold", calc_rst, 0);
        reset = 1'b0;
        calc_status = ST_READY;
        tick(); tick();
        checkOutput("t6_idle", issue_active, 0);
        checkOutput("t6_no_rst_pulse", calc_rst, 0);

        checkOutput("sb_drain", expQ.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/calc_cmd_sched.md
# calc_cmd_sched

Command scheduler that sits between the keypad front end and the `calc` calculator core. It buffers key codes in a small FIFO and drives the calculator's 4-bit `cmd` input one code at a time. It issues a code only when the core reports ready, and waits for the core's busy→ready handshake before issuing the next. It also detects core error and hang conditions and owns the core's reset for error recovery.

## Interface
Parameters:
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `TIMEOUT`, 1024: maximum cycles one command may spend in ISSUE+BUSY before a hang is declared.

Ports:
- `clock` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-high; clock `clock`.
- `key_valid` in 1: key code offered this cycle.
- `key_code` in 4: 0–9 digit, 1010 add, 1011 sub, 1100 mul, 1110 equals, 1111 backspace.
- `key_ready` out 1: a push is accepted when `key_valid && key_ready`.
- `clr` in 1: synchronous error-clear request.
- `calc_status` in 2: core status; 00 error, 01 busy, 10 ready, 11 illegal.
- `cmd` out 4: command presented to the core.
- `calc_rst` out 1: one-cycle reset pulse to the core.
- `issue_active` out 1: high in ISSUE or BUSY.
- `err` out 1: high in ERROR.
- `timeout` out 1: high in ERROR when the error was caused by a hang.
- `dropped` out 1: one-cycle pulse when an offered key is discarded.
- `fifo_count` out $clog2(DEPTH)+1: current occupancy.

## Operation
- States are IDLE, ISSUE, BUSY, ERROR. Reset enters IDLE.
- Reset values: `cmd`=0, `calc_rst`=0, `err`=0, `timeout`=0, `dropped`=0, `fifo_count`=0, `issue_active`=0.
- `key_ready` = (`fifo_count` < DEPTH) && state != ERROR. It is derived from registered values only and does not depend on a same-cycle pop.
- Key code 1101 is undefined. An offered 1101 is not pushed, and `dropped` pulses.
- In ERROR, every offered key is dropped and `dropped` pulses.
- IDLE → ISSUE when `fifo_count`>0 and `calc_status`==10. On that edge the FIFO head is popped into `cmd`.
- ISSUE → BUSY when `calc_status`==01, meaning the core has accepted the command.
- BUSY → IDLE when `calc_status`==10. The next command may issue on the following edge.
- `cmd` holds its last value in all states except on a pop. It is cleared to 0 on entry to ERROR.
- Any state except ERROR → ERROR when `calc_status`==00 or 11. `timeout` stays 0 in this case.
- Hang timer: cleared on entry to ISSUE and incremented in ISSUE and BUSY. When it reaches TIMEOUT−1 the block enters ERROR with `timeout`=1.
- On entry to ERROR the FIFO is flushed and `fifo_count`=0.
- ERROR + `clr` → IDLE. On that edge `calc_rst` pulses for one cycle and `err`/`timeout` clear.
- `clr` has no effect outside ERROR.
- Push and pop may occur in the same cycle; `fifo_count` is then unchanged.
- Pointers wrap modulo DEPTH.

## Timing
- Key accepted at edge N: it is visible in `fifo_count` after edge N.
- If IDLE and the core is ready, `cmd` updates at edge N+1. This is minimum 1-cycle key-to-cmd latency with an empty FIFO.
- Back-to-back commands: minimum spacing is 3 edges (issue, busy seen, ready seen), plus the core's busy time.
- Error detection is 1 edge: `calc_status`==00 sampled at edge M gives `err`=1 after edge M.
- `calc_rst` is registered and is high for exactly the cycle after the `clr` edge.
- An asynchronous `reset` mid-command abandons the command and empties the FIFO. It does not pulse `calc_rst`; the system reset drives the core directly.

## Structure
- `calc_pkg` holds:
  - status localparams: ST_ERR=2'b00, ST_BUSY=2'b01, ST_READY=2'b10;
  - command codes: CMD_ADD=4'b1010, CMD_SUB=4'b1011, CMD_MUL=4'b1100, CMD_EQ=4'b1110, CMD_BS=4'b1111, CMD_BAD=4'b1101;
  - the `sched_state_t` enum.
- Sub-module `cmd_fifo` contains the FIFO: DEPTH×4 storage, read/write pointers, count, synchronous flush. It has no knowledge of codes.

## Test plan
- Empty FIFO, status 10: push 5 → `cmd`=5 one edge later. With status then 01 for 10 cycles and back to 10, the block returns to IDLE with `issue_active` low.
- Status held 01: push 1, 2, 1010, 3 → `fifo_count`=4 and `key_ready`=0. A 5th key is not accepted. Codes then issue in order 1, 2, 1010, 3 as status cycles 10→01→10.
- Push 1101 → `dropped` pulses, `fifo_count` unchanged, `cmd` unchanged.
- In BUSY with 2 keys queued, force `calc_status`=00 → `err`=1, `fifo_count`=0, `cmd`=0, keys dropped. Assert `clr` → one-cycle `calc_rst`, then IDLE.
- With TIMEOUT=16, issue a command while status stays 10 (never accepted) → after 15 cycles in ISSUE, `err`=1 and `timeout`=1.
- Asserting `reset` mid-BUSY with 3 queued → all outputs at their reset values immediately; no `calc_rst` pulse.
